cache_dados_wt: RTL and testbench

Parametrised direct-mapped data cache for the RISC-V pipeline MEM stage. It is the successor of the fixed 16-line read-only data cache.
- Adds a line refill from main memory on read miss: burst of one-word beats.
- Adds word stores: write-through, no-write-allocate.
- Exposes a simple valid/ready memory port.
- Stalls the pipeline while any memory transaction is outstanding.

---
 rtl/cache_dados_pkg.sv | 31 +++
 rtl/cache_dados_array.sv | 69 ++++++
 rtl/cache_dados_wt.sv | 203 ++++++++++++++++++++
 tb/tb_cache_dados_wt.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_dados_pkg.sv
// Shared definitions for the write-through data cache: FSM encoding, log2 helper
// and the address-split widths derived from the cache geometry.
package cache_dados_pkg;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] REFILL  = 2'd1;
  localparam logic [1:0] ESCRITA = 2'd2;
  localparam logic [1:0] CONCLUI = 2'd3;

  function automatic int log2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < valor) ? i + 1 : r;
    end
    return r;
  endfunction

  function automatic int off_w(input int palavras_bloco);
    return log2(palavras_bloco) + 2;
  endfunction

  function automatic int idx_w(input int n_linhas);
    return log2(n_linhas);
  endfunction

  function automatic int tag_w(input int n_linhas, input int palavras_bloco);
    return 32 - idx_w(n_linhas) - off_w(palavras_bloco);
  endfunction

endpackage

// File: rtl/cache_dados_array.sv
// Tag/valid/data storage for the direct-mapped cache: one line write port,
// one word write port, and two combinational lookups.
module cache_dados_array
  import cache_dados_pkg::*;
#(
  parameter int N_LINHAS       = 16,
  parameter int PALAVRAS_BLOCO = 8,
  localparam int IDX_W = idx_w(N_LINHAS),
  localparam int TAG_W = tag_w(N_LINHAS, PALAVRAS_BLOCO),
  localparam int PAL_W = off_w(PALAVRAS_BLOCO) - 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             line_we,
  input  logic [IDX_W-1:0] line_idx,
  input  logic [TAG_W-1:0] line_tag,
  input  logic             line_valid,
  input  logic             word_we,
  input  logic [IDX_W-1:0] word_idx,
  input  logic [PAL_W-1:0] word_sel,
  input  logic [31:0]      word_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [PAL_W-1:0] rd_sel,
  output logic [31:0]      rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic [IDX_W-1:0] chk_idx,
  output logic             chk_valid,
  output logic [TAG_W-1:0] chk_tag
);

  logic [N_LINHAS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [N_LINHAS];
  logic [TAG_W-1:0]    tag_d  [N_LINHAS];
  logic [31:0]         data_q [N_LINHAS][PALAVRAS_BLOCO];
  logic [31:0]         data_d [N_LINHAS][PALAVRAS_BLOCO];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d[line_idx] = line_we ? line_valid : valid_q[line_idx];
    tag_d[line_idx]   = line_we ? line_tag : tag_q[line_idx];
    data_d[word_idx][word_sel] = word_we ? word_data : data_q[word_idx][word_sel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < N_LINHAS; i++) begin
        tag_q[i] <= '0;
        for (int j = 0; j < PALAVRAS_BLOCO; j++) begin
          data_q[i][j] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign rd_word   = data_q[rd_idx][rd_sel];
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign chk_valid = valid_q[chk_idx];
  assign chk_tag   = tag_q[chk_idx];

endmodule

// File: rtl/cache_dados_wt.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage:
// burst line refill on read miss, single-beat store, pipeline stall while busy.
module cache_dados_wt
  import cache_dados_pkg::*;
#(
  parameter int N_LINHAS       = 16,
  parameter int PALAVRAS_BLOCO = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] endereco,
  input  logic [31:0] dado_escrita,
  output logic [31:0] dado_lido,
  output logic        stall_cache_dados,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = off_w(PALAVRAS_BLOCO);
  localparam int IDX_W = idx_w(N_LINHAS);
  localparam int TAG_W = tag_w(N_LINHAS, PALAVRAS_BLOCO);
  localparam int PAL_W = OFF_W - 2;
  localparam logic [PAL_W-1:0] ULTIMA = PAL_W'(PALAVRAS_BLOCO - 1);

  logic [1:0]       state_q, state_d;
  logic [PAL_W-1:0] beat_q, beat_d;
  logic [TAG_W-1:0] tag_l_q, tag_l_d;
  logic [IDX_W-1:0] idx_l_q, idx_l_d;
  logic [29:0]      addr_l_q, addr_l_d;
  logic [31:0]      wdata_l_q, wdata_l_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0] tag_s, rd_tag_s, chk_tag_s, line_tag_s;
  logic [IDX_W-1:0] idx_s, line_idx_s, word_idx_s;
  logic [PAL_W-1:0] pal_s, word_sel_s;
  logic [31:0]      word_data_s;
  logic             rd_valid_s, chk_valid_s, hit_s, hit_esc_s;
  logic             line_we_s, line_valid_s, word_we_s, stall_s;
  logic             unused_s;

  assign tag_s    = endereco[31 -: TAG_W];
  assign idx_s    = endereco[OFF_W +: IDX_W];
  assign pal_s    = endereco[2 +: PAL_W];
  assign unused_s = ^endereco[1:0];

  assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);
  assign hit_esc_s = chk_valid_s && (chk_tag_s == addr_l_q[29 -: TAG_W]);

  cache_dados_array #(
    .N_LINHAS      (N_LINHAS),
    .PALAVRAS_BLOCO(PALAVRAS_BLOCO)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .line_we   (line_we_s),
    .line_idx  (line_idx_s),
    .line_tag  (line_tag_s),
    .line_valid(line_valid_s),
    .word_we   (word_we_s),
    .word_idx  (word_idx_s),
    .word_sel  (word_sel_s),
    .word_data (word_data_s),
    .rd_idx    (idx_s),
    .rd_sel    (pal_s),
    .rd_word   (dado_lido),
    .rd_valid  (rd_valid_s),
    .rd_tag    (rd_tag_s),
    .chk_idx   (addr_l_q[PAL_W +: IDX_W]),
    .chk_valid (chk_valid_s),
    .chk_tag   (chk_tag_s)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    tag_l_d      = tag_l_q;
    idx_l_d      = idx_l_q;
    addr_l_d     = addr_l_q;
    wdata_l_d    = wdata_l_q;
    stall_s      = 1'b0;
    line_we_s    = 1'b0;
    line_idx_s   = idx_l_q;
    line_tag_s   = tag_l_q;
    line_valid_s = 1'b0;
    word_we_s    = 1'b0;
    word_idx_s   = idx_l_q;
    word_sel_s   = beat_q;
    word_data_s  = mem_rdata;
    case (state_q)
      OCIOSO: begin
        if (MemWrite) begin
          stall_s   = 1'b1;
          addr_l_d  = endereco[31:2];
          wdata_l_d = dado_escrita;
          state_d   = ESCRITA;
        end else if (MemRead && !hit_s) begin
          // The line is invalidated up front so an abandoned refill never looks valid.
          stall_s    = 1'b1;
          tag_l_d    = tag_s;
          idx_l_d    = idx_s;
          line_we_s  = 1'b1;
          line_idx_s = idx_s;
          line_tag_s = tag_s;
          beat_d     = '0;
          state_d    = REFILL;
        end else begin
          stall_s = 1'b0;
        end
      end
      REFILL: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          word_we_s    = 1'b1;
          beat_d       = beat_q + PAL_W'(1);
          line_we_s    = (beat_q == ULTIMA);
          line_valid_s = 1'b1;
          state_d      = (beat_q == ULTIMA) ? OCIOSO : REFILL;
        end else begin
          beat_d = beat_q;
        end
      end
      ESCRITA: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          word_we_s   = hit_esc_s;
          word_idx_s  = addr_l_q[PAL_W +: IDX_W];
          word_sel_s  = addr_l_q[0 +: PAL_W];
          word_data_s = wdata_l_q;
          state_d     = CONCLUI;
        end else begin
          state_d = ESCRITA;
        end
      end
      CONCLUI: begin
        stall_s = 1'b0;
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Memory-port outputs are registered from next-state values so they line up with the FSM.
  always_comb begin
    mem_req_d = (state_d == REFILL) || (state_d == ESCRITA);
    mem_we_d  = (state_d == ESCRITA);
    case (state_d)
      REFILL: begin
        mem_addr_d  = {tag_l_d, idx_l_d, beat_d, 2'b00};
        mem_wdata_d = '0;
      end
      ESCRITA: begin
        mem_addr_d  = {addr_l_d, 2'b00};
        mem_wdata_d = wdata_l_d;
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      beat_q      <= '0;
      tag_l_q     <= '0;
      idx_l_q     <= '0;
      addr_l_q    <= '0;
      wdata_l_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tag_l_q     <= tag_l_d;
      idx_l_q     <= idx_l_d;
      addr_l_q    <= addr_l_d;
      wdata_l_q   <= wdata_l_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign stall_cache_dados = stall_s;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;

endmodule

// File: tb/tb_cache_dados_wt.sv
// Bench for cache_dados_wt: directed table, reset-mid-refill sequence, random
// loads/stores against a memory-level reference model, and a second geometry.
module tb_cache_dados_wt;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0, a_data = '0;
  logic [31:0] a_dado, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_stall, a_mem_req, a_mem_we, a_mem_ready;

  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = '0, b_data = '0;
  logic [31:0] b_dado, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_stall, b_mem_req, b_mem_we, b_mem_ready;

  cache_dados_wt #(.N_LINHAS(16), .PALAVRAS_BLOCO(8)) dut_a (
    .clock(clock), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
    .endereco(a_addr), .dado_escrita(a_data), .dado_lido(a_dado),
    .stall_cache_dados(a_stall), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ready(a_mem_ready),
    .mem_rdata(a_mem_rdata)
  );

  cache_dados_wt #(.N_LINHAS(64), .PALAVRAS_BLOCO(4)) dut_b (
    .clock(clock), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
    .endereco(b_addr), .dado_escrita(b_data), .dado_lido(b_dado),
    .stall_cache_dados(b_stall), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ready(b_mem_ready),
    .mem_rdata(b_mem_rdata)
  );

  // Main memory for dut_a: 4 KiB, initialised so that each word holds its own address.
  logic [31:0] mem_arr [1024];
  bit          mem_init_done = 1'b0;
  int          wait_cfg = 0;
  int          wcnt;
  logic [31:0] a_log_addr[$], a_log_wdata[$], b_log_addr[$];
  logic        a_log_we[$], b_log_we[$];

  assign a_mem_ready = a_mem_req && (wcnt >= wait_cfg);
  assign a_mem_rdata = mem_arr[a_mem_addr[11:2]];
  assign b_mem_ready = b_mem_req;
  assign b_mem_rdata = b_mem_addr;

  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'(i * 4);
      mem_init_done <= 1'b1;
    end else if (a_mem_req && a_mem_ready && a_mem_we) begin
      mem_arr[a_mem_addr[11:2]] <= a_mem_wdata;
    end
    if (reset || !a_mem_req || a_mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (a_mem_req && a_mem_ready) begin
      a_log_addr.push_back(a_mem_addr);
      a_log_we.push_back(a_mem_we);
      a_log_wdata.push_back(a_mem_wdata);
    end
    if (b_mem_req && b_mem_ready) begin
      b_log_addr.push_back(b_mem_addr);
      b_log_we.push_back(b_mem_we);
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: loads always return what memory holds; line residency per index.
  logic [31:0] ref_mem [1024];
  bit          mvalid [16];
  logic [31:0] mtag [16];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic cur_stall(input bit s);
    return s ? b_stall : a_stall;
  endfunction

  task automatic do_op(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data, input int wt,
                       input int exp_stall, input int exp_beats, input logic [31:0] exp_first,
                       input logic exp_we, input logic chk, input logic [31:0] exp_dado,
                       input string nm);
    int n, base, got;
    logic [31:0] ba;
    logic        bw;
    wait_cfg = wt;
    @(negedge clock);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_data = data;
      base = b_log_addr.size();
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_data = data;
      base = a_log_addr.size();
    end
    n = 0;
    #1;
    while (cur_stall(sel) && n < 1000) begin
      n++;
      @(negedge clock);
      #1;
    end
    chk32({nm, " stall cycles"}, 32'(n), 32'(exp_stall));
    got = (sel ? b_log_addr.size() : a_log_addr.size()) - base;
    chk32({nm, " beats"}, 32'(got), 32'(exp_beats));
    if (got == exp_beats) begin
      for (int k = 0; k < got; k++) begin
        ba = sel ? b_log_addr[base + k] : a_log_addr[base + k];
        bw = sel ? b_log_we[base + k] : a_log_we[base + k];
        chk32({nm, " beat addr"}, ba, exp_first + 32'(4 * k));
        chk32({nm, " beat we"}, {31'd0, bw}, {31'd0, exp_we});
        if (exp_we && !sel) chk32({nm, " beat wdata"}, a_log_wdata[base + k], data);
      end
    end
    chk32({nm, " mem_req idle"}, {31'd0, sel ? b_mem_req : a_mem_req}, 32'd0);
    if (chk) chk32({nm, " dado_lido"}, sel ? b_dado : a_dado, exp_dado);
    if (sel) begin b_rd = 1'b0; b_wr = 1'b0; end
    else begin a_rd = 1'b0; a_wr = 1'b0; end
  endtask

  task automatic model_update(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data);
    if (wr) ref_mem[addr[11:2]] = data;
    else if (rd) begin
      mvalid[addr[8:5]] = 1'b1;
      mtag[addr[8:5]]   = addr >> 9;
    end
  endtask

  task automatic model_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int wt, input string nm);
    bit hit;
    hit = mvalid[addr[8:5]] && (mtag[addr[8:5]] == (addr >> 9));
    if (wr)
      do_op(1'b0, rd, wr, addr, data, wt, 2 + wt, 1, addr & ~32'h3, 1'b1, 1'b0, 32'h0, nm);
    else
      do_op(1'b0, rd, wr, addr, data, wt, hit ? 0 : 1 + 8 * (1 + wt), hit ? 0 : 8,
            addr & ~32'h1F, 1'b0, 1'b1, ref_mem[addr[11:2]], nm);
    model_update(rd, wr, addr, data);
  endtask

  typedef struct {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] data; int wt;
    int stall; int beats; logic [31:0] first; logic we; logic chk; logic [31:0] dado;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n;
    int base;
    logic [31:0] ra;
    int kind;
    tbl[0]  = '{1'b1, 1'b0, 32'h124, 32'h0,        0, 9, 8, 32'h120, 1'b0, 1'b1, 32'h124};
    tbl[1]  = '{1'b1, 1'b0, 32'h13C, 32'h0,        0, 0, 0, 32'h0,   1'b0, 1'b1, 32'h13C};
    tbl[2]  = '{1'b1, 1'b0, 32'h324, 32'h0,        0, 9, 8, 32'h320, 1'b0, 1'b1, 32'h324};
    tbl[3]  = '{1'b1, 1'b0, 32'h124, 32'h0,        0, 9, 8, 32'h120, 1'b0, 1'b1, 32'h124};
    tbl[4]  = '{1'b0, 1'b1, 32'h128, 32'hDEADBEEF, 2, 4, 1, 32'h128, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h128, 32'h0,        0, 0, 0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 32'h528, 32'h12345678, 0, 2, 1, 32'h528, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h128, 32'h0,        0, 0, 0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 1'b0, 32'h124, 32'h0,        0, 0, 0, 32'h0,   1'b0, 1'b1, 32'h124};
    tbl[9]  = '{1'b1, 1'b1, 32'h40,  32'hCAFEF00D, 0, 2, 1, 32'h40,  1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h40,  32'h0,        0, 9, 8, 32'h40,  1'b0, 1'b1, 32'hCAFEF00D};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i * 4);
    for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end

    repeat (3) @(negedge clock);
    #1;
    chk32("reset mem_req", {31'd0, a_mem_req}, 32'd0);
    chk32("reset mem_we", {31'd0, a_mem_we}, 32'd0);
    chk32("reset mem_addr", a_mem_addr, 32'h0);
    chk32("reset mem_wdata", a_mem_wdata, 32'h0);
    chk32("reset stall", {31'd0, a_stall}, 32'd0);
    chk32("reset dado_lido", a_dado, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].wt, tbl[i].stall,
            tbl[i].beats, tbl[i].first, tbl[i].we, tbl[i].chk, tbl[i].dado,
            $sformatf("vec%0d", i));
      model_update(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
    end

    // Reset during beat 4 of a refill: transaction dropped, line left invalid.
    model_op(1'b1, 1'b0, 32'h324, 32'h0, 0, "evict9");
    wait_cfg = 0;
    @(negedge clock);
    a_rd = 1'b1; a_addr = 32'h124;
    base = a_log_addr.size();
    n = 0;
    while ((a_log_addr.size() - base) < 4 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk32("rst_mid beats before reset", 32'(a_log_addr.size() - base), 32'd4);
    reset = 1'b1;
    #1;
    chk32("rst_mid mem_req", {31'd0, a_mem_req}, 32'd0);
    chk32("rst_mid dado_lido", a_dado, 32'h0);
    chk32("rst_mid stall", {31'd0, a_stall}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    a_rd = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    model_op(1'b1, 1'b0, 32'h124, 32'h0, 0, "rst_mid refill");

    for (int i = 0; i < 150; i++) begin
      ra   = 32'($urandom_range(0, 1023) * 4) | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      model_op(kind != 2, kind >= 2, ra, $urandom, $urandom_range(0, 2),
               $sformatf("rnd%0d", i));
    end

    do_op(1'b1, 1'b1, 1'b0, 32'h124, 32'h0, 0, 5, 4, 32'h120, 1'b0, 1'b1, 32'h124, "g64 miss");
    do_op(1'b1, 1'b1, 1'b0, 32'h12C, 32'h0, 0, 0, 0, 32'h0, 1'b0, 1'b1, 32'h12C, "g64 hit");
    do_op(1'b1, 1'b1, 1'b0, 32'h130, 32'h0, 0, 5, 4, 32'h130, 1'b0, 1'b1, 32'h130, "g64 next");
    do_op(1'b1, 1'b1, 1'b0, 32'h524, 32'h0, 0, 5, 4, 32'h520, 1'b0, 1'b1, 32'h524, "g64 conf");
    do_op(1'b1, 1'b1, 1'b0, 32'h124, 32'h0, 0, 5, 4, 32'h120, 1'b0, 1'b1, 32'h124, "g64 remiss");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
